// File: rtl/game_over_sequencer.sv
// GAME OVER overlay sequencer: typewriter reveal of the eight letters, then blink,
// then a debounced-by-edge restart request once the hold period has elapsed.
module game_over_sequencer #(
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 30,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       restart_key,
    input  logic [5:0] glyph_x,
    input  logic [4:0] glyph_y,
    input  logic       glyph_pixel,
    output logic [7:0] letter_mask,
    output logic       text_on,
    output logic       text_pixel,
    output logic       restart,
    output logic       active
);

    localparam int FW = $clog2(REVEAL_FRAMES) + 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    localparam int HW = $clog2(HOLD_FRAMES) + 1;
    localparam int LW = $clog2(8) + 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(REVEAL_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);
    localparam logic [LW-1:0] LAST_LETTER = LW'(7);
    localparam logic [LW-1:0] ALL_LETTERS = LW'(8);

    typedef enum logic [1:0] {ST_IDLE, ST_REVEAL, ST_BLINK} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   letter_cnt_q, letter_cnt_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            go_prev_q, go_prev_d;
    logic            key_prev_q, key_prev_d;
    logic [7:0]      letter_mask_q, letter_mask_d;
    logic            text_on_q, text_on_d;
    logic            restart_q, restart_d;
    logic            active_q, active_d;

    logic            go_rise;
    logic            key_rise;
    logic [2:0]      letter_idx;
    logic            unused_glyph_bits;

    function automatic logic [7:0] thermometer(input logic [LW-1:0] n);
        thermometer = 8'((9'd1 << n) - 9'd1);
    endfunction

    function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] cnt);
        hold_sat_inc = (cnt == HOLD_MAX) ? HOLD_MAX : cnt + HW'(1);
    endfunction

    assign go_rise  = game_over & ~go_prev_q;
    assign key_rise = restart_key & ~key_prev_q;

    always_comb begin
        state_d      = state_q;
        letter_cnt_d = letter_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        text_on_d    = text_on_q;
        restart_d    = 1'b0;
        go_prev_d    = game_over;
        key_prev_d   = restart_key;

        case (state_q)
            ST_IDLE: begin
                if (go_rise) begin
                    state_d      = ST_REVEAL;
                    letter_cnt_d = '0;
                    frame_cnt_d  = '0;
                    text_on_d    = 1'b1;
                end
            end
            ST_REVEAL: begin
                // Abort beats the skip key, which beats the frame tick.
                if (!game_over) begin
                    state_d = ST_IDLE;
                end else if (key_rise || (frame_tick && frame_cnt_q == FRAME_LAST
                                          && letter_cnt_q == LAST_LETTER)) begin
                    state_d      = ST_BLINK;
                    letter_cnt_d = ALL_LETTERS;
                    frame_cnt_d  = '0;
                    blink_cnt_d  = '0;
                    hold_cnt_d   = '0;
                    text_on_d    = 1'b1;
                end else if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d  = '0;
                        letter_cnt_d = letter_cnt_q + LW'(1);
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            ST_BLINK: begin
                if (!game_over) begin
                    state_d = ST_IDLE;
                end else if (key_rise && hold_cnt_q == HOLD_MAX) begin
                    state_d   = ST_IDLE;
                    restart_d = 1'b1;
                end else if (frame_tick) begin
                    hold_cnt_d = hold_sat_inc(hold_cnt_q);
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        text_on_d   = ~text_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        letter_mask_d = 8'h00;
        active_d      = (state_d != ST_IDLE);
        case (state_d)
            ST_REVEAL: letter_mask_d = thermometer(letter_cnt_d);
            ST_BLINK:  letter_mask_d = 8'hFF;
            default: begin
                letter_mask_d = 8'h00;
                text_on_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            letter_cnt_q  <= '0;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            go_prev_q     <= 1'b0;
            // A key held through reset must not count as a fresh press.
            key_prev_q    <= 1'b1;
            letter_mask_q <= 8'h00;
            text_on_q     <= 1'b0;
            restart_q     <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            letter_cnt_q  <= letter_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            go_prev_q     <= go_prev_d;
            key_prev_q    <= key_prev_d;
            letter_mask_q <= letter_mask_d;
            text_on_q     <= text_on_d;
            restart_q     <= restart_d;
            active_q      <= active_d;
        end
    end

    // Letter slot: top/bottom row from y[4], column of four 8-px letters from x[4:3].
    assign letter_idx        = {glyph_y[4], glyph_x[4:3]};
    assign unused_glyph_bits = ^{glyph_y[3:0], glyph_x[2:0]};
    assign text_pixel        = glyph_pixel & text_on_q & ~glyph_x[5] & letter_mask_q[letter_idx];

    assign letter_mask = letter_mask_q;
    assign text_on     = text_on_q;
    assign restart     = restart_q;
    assign active      = active_q;

endmodule

// File: tb/tb_game_over_sequencer.sv
// Scoreboard bench for game_over_sequencer: a tick-counting reference model pushes expected
// outputs per cycle; a monitor pops and compares one entry after every rising clock edge.
module tb_game_over_sequencer;

    localparam int RF = 2;
    localparam int BF = 3;
    localparam int HF = 4;
    localparam int TICK_PERIOD = 5;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       game_over;
    logic       restart_key;
    logic [5:0] glyph_x;
    logic [4:0] glyph_y;
    logic       glyph_pixel;
    logic [7:0] letter_mask;
    logic       text_on;
    logic       text_pixel;
    logic       restart;
    logic       active;

    game_over_sequencer #(
        .REVEAL_FRAMES(RF),
        .BLINK_FRAMES (BF),
        .HOLD_FRAMES  (HF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .restart_key(restart_key),
        .glyph_x    (glyph_x),
        .glyph_y    (glyph_y),
        .glyph_pixel(glyph_pixel),
        .letter_mask(letter_mask),
        .text_on    (text_on),
        .text_pixel (text_pixel),
        .restart    (restart),
        .active     (active)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] mask;
        logic       ton;
        logic       pix;
        logic       rs;
        logic       act;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: phase (0 idle, 1 reveal, 2 blink) plus frame ticks seen in that phase.
    int    m_phase = 0;
    int    m_rt    = 0;
    int    m_bt    = 0;
    bit    m_go_prev  = 1'b0;
    bit    m_key_prev = 1'b1;
    bit    m_rs       = 1'b0;
    int    cyc        = 0;
    string cur_tag    = "init";

    task automatic check_val(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=condition_reached", name);
    endtask

    function automatic int m_hold();
        return (m_bt < HF) ? m_bt : HF;
    endfunction

    function automatic logic [7:0] m_mask();
        if (m_phase == 1) return 8'((1 << (m_rt / RF)) - 1);
        if (m_phase == 2) return 8'hFF;
        return 8'h00;
    endfunction

    function automatic bit m_ton();
        if (m_phase == 1) return 1'b1;
        if (m_phase == 2) return ((m_bt / BF) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input bit go, input bit key,
                        input logic [5:0] gx, input logic [4:0] gy, input bit gp);
        bit         tick, go_rise, key_rise;
        exp_t       e;
        logic [7:0] mk;
        int         idx;
        @(negedge Clk);
        cyc++;
        tick        = (cyc % TICK_PERIOD) == 0;
        Reset       = rst;
        game_over   = go;
        restart_key = key;
        frame_tick  = tick;
        glyph_x     = gx;
        glyph_y     = gy;
        glyph_pixel = gp;

        if (rst) begin
            m_phase = 0; m_rt = 0; m_bt = 0;
            m_go_prev = 1'b0; m_key_prev = 1'b1; m_rs = 1'b0;
        end else begin
            go_rise  = go && !m_go_prev;
            key_rise = key && !m_key_prev;
            m_rs     = 1'b0;
            case (m_phase)
                0: if (go_rise) begin m_phase = 1; m_rt = 0; end
                1: begin
                    if (!go) m_phase = 0;
                    else if (key_rise) begin m_phase = 2; m_bt = 0; end
                    else if (tick) begin
                        m_rt++;
                        if (m_rt == 8 * RF) begin m_phase = 2; m_bt = 0; end
                    end
                end
                default: begin
                    if (!go) m_phase = 0;
                    else if (key_rise && m_hold() == HF) begin m_rs = 1'b1; m_phase = 0; end
                    else if (tick) m_bt++;
                end
            endcase
            m_go_prev  = go;
            m_key_prev = key;
        end

        mk     = m_mask();
        e.mask = mk;
        e.ton  = m_ton();
        e.rs   = m_rs;
        e.act  = (m_phase != 0);
        idx    = (int'(gy) >= 16 ? 4 : 0) + int'(gx) / 8;
        e.pix  = gp && e.ton && (int'(gx) < 32) && mk[idx[2:0]];
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);

        if (rst) begin
            #1;
            check_val({cur_tag, "_async_mask"},   int'(letter_mask), 0);
            check_val({cur_tag, "_async_active"}, int'(active), 0);
            check_val({cur_tag, "_async_texton"}, int'(text_on), 0);
            check_val({cur_tag, "_async_restart"}, int'(restart), 0);
        end
    endtask

    task automatic rstep(input bit rst, input bit go, input bit key);
        step(rst, go, key, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 1'($urandom));
    endtask

    // Monitor: the DUT presents a new output set after every rising edge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_val({t, "_mask"},    int'(letter_mask), int'(e.mask));
                check_val({t, "_text_on"}, int'(text_on),     int'(e.ton));
                check_val({t, "_pixel"},   int'(text_pixel),  int'(e.pix));
                check_val({t, "_restart"}, int'(restart),     int'(e.rs));
                check_val({t, "_active"},  int'(active),      int'(e.act));
            end
        end
    end

    initial begin
        bit go_r, key_r;
        Reset = 1'b1; game_over = 1'b0; restart_key = 1'b1; frame_tick = 1'b0;
        glyph_x = '0; glyph_y = '0; glyph_pixel = 1'b0;

        cur_tag = "reset";
        repeat (3) rstep(1, 0, 1);

        // Reach BLINK, then reset there with the key held.
        cur_tag = "to_blink";
        rstep(0, 0, 0);
        for (int i = 0; i < 300 && m_phase != 2; i++) rstep(0, 1, 0);
        if (m_phase != 2) bound_expired("to_blink_wait");
        repeat (3) rstep(0, 1, 1);
        cur_tag = "reset_blink";
        repeat (2) rstep(1, 0, 1);
        cur_tag = "post_reset";
        repeat (3) rstep(0, 0, 1);
        rstep(0, 0, 0);

        cur_tag = "full_reveal";
        for (int i = 0; i < 300 && m_phase != 2; i++) rstep(0, 1, 0);
        if (m_phase != 2) bound_expired("full_reveal_wait");

        cur_tag = "blink_early_key";
        for (int i = 0; i < 100 && m_hold() != 2; i++) rstep(0, 1, 0);
        if (m_hold() != 2) bound_expired("hold2_wait");
        repeat (5) rstep(0, 1, 1);
        cur_tag = "blink_restart";
        for (int i = 0; i < 100 && m_hold() != HF; i++) rstep(0, 1, 0);
        if (m_hold() != HF) bound_expired("hold_full_wait");
        repeat (12) rstep(0, 1, 0);
        rstep(0, 1, 1);
        repeat (3) rstep(0, 1, 1);
        repeat (3) rstep(0, 0, 0);

        cur_tag = "skip_reveal";
        for (int i = 0; i < 100 && m_mask() != 8'h07; i++) rstep(0, 1, 0);
        if (m_mask() != 8'h07) bound_expired("mask07_wait");
        rstep(0, 1, 1);
        repeat (4) rstep(0, 1, 0);
        repeat (2) rstep(0, 0, 0);

        cur_tag = "abort_reveal";
        for (int i = 0; i < 200 && m_mask() != 8'h1F; i++) rstep(0, 1, 0);
        if (m_mask() != 8'h1F) bound_expired("mask1f_wait");
        repeat (3) rstep(0, 0, 0);

        cur_tag = "pixel_gate";
        for (int i = 0; i < 100 && m_mask() != 8'h03; i++) rstep(0, 1, 0);
        if (m_mask() != 8'h03) bound_expired("mask03_wait");
        step(0, 1, 0, 6'd9,  5'd3,  1'b1);
        step(0, 1, 0, 6'd17, 5'd3,  1'b1);
        step(0, 1, 0, 6'd1,  5'd20, 1'b1);
        step(0, 1, 0, 6'd40, 5'd3,  1'b1);
        repeat (2) rstep(0, 0, 0);

        cur_tag = "random";
        go_r = 1'b0; key_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (go_r) go_r = ($urandom_range(0, 299) != 0);
            else      go_r = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) key_r = ~key_r;
            rstep(($urandom_range(0, 999) == 0), go_r, key_r);
        end

        @(posedge Clk);
        #2;
        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
